sseg_mux_driver: RTL and testbench
==================================

# sseg_mux_driver

Time-multiplexed four-digit seven-segment driver that sits directly downstream of the heartbeat pattern generator. Accepts a 32-bit raw segment pattern (four digits, active-low segments plus decimal point) through a ready/load handshake and scans it onto the shared anode and segment pins. The pattern is double-buffered and swapped only at frame boundaries, so the display never shows a torn frame. `frame_o` pulses once per scan so the upstream generator can pace its animation.

## Interface
- `N`, default 18: refresh counter width; slot length 2^(N-2) cycles, frame length 2^N cycles; legal range N ≥ 4.
- `BLANK_CYCLES`, default 4: anode-off cycles at the start of each slot when blanking is compiled in; must be < 2^(N-2).

- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `pattern_i`  in  32  digit k in bits [8k+7:8k] as {dp, g, f, e, d, c, b, a}, all active-low.
- `load_i`  in  1  capture `pattern_i` when `ready_o` is high.
- `ready_o`  out  1  pending buffer empty; a load will be accepted.
- `digit_en_i`  in  4  per-digit enable; 0 keeps that anode off.
- `an_o`  out  4  active-low anodes, one-hot-low or all high.
- `sseg_o`  out  7  active-low segments {g..a}.
- `dp_o`  out  1  active-low decimal point.
- `frame_o`  out  1  one-cycle pulse marking the start of a frame.

## Operation
- Refresh counter `cnt[N-1:0]` increments every cycle and wraps freely. Digit index is `cnt[N-1:N-2]`; digit 0 is scanned first.
- Pending buffer:
  - On an edge with `load_i` and `ready_o` both high, `pattern_i` is captured into pending and `ready_o` goes low.
  - `load_i` while `ready_o` is low is ignored; the pending contents are not overwritten.
- Frame swap: on the edge where `cnt` wraps from all-ones to 0, if pending is valid, active ← pending and pending is cleared. `ready_o` is high from the next cycle.
- Simultaneous events on the wrap edge:
  - With `ready_o` low, the swap happens and the load is ignored.
  - With `ready_o` high (pending empty), the load is captured into pending and is not displayed until the following wrap.
- Output register, updated every edge from the pre-edge `cnt` and active buffer:
  - `an_o` is low only on the bit for the current index, and only if `digit_en_i` for that index is high.
  - `sseg_o`/`dp_o` carry the active byte for the current index when the digit is enabled, otherwise all 1s.
- `frame_o` is registered `(cnt == 2^N-1)`, so it is high during the cycle in which `cnt == 0`.
- Reset values:
  - `cnt` = 0; active buffer = 32'hFFFF_FFFF; pending invalid.
  - `ready_o` = 1, `an_o` = 4'b1111, `sseg_o` = 7'h7F, `dp_o` = 1, `frame_o` = 0.
- Reset mid-operation discards pending and active contents; the display blanks on the next cycle.

## Timing
- Latency from counter to pins is 1 cycle: `an_o` during cycle t+1 reflects `cnt` at cycle t.
- The first displayed cycle of the new pattern is the second cycle after the wrap edge (cnt = 1 region), on digit 0.
- `ready_o` rises exactly 1 cycle after the swap edge; earliest reload is on that cycle's rising edge.
- Worst-case load-to-display time is one full frame (2^N cycles) plus 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SSEG_MUX_BLANK_EN` defined: while `cnt[N-3:0] < BLANK_CYCLES`, the registered `an_o` is forced to 4'b1111 and `sseg_o`/`dp_o` to all 1s. This suppresses ghosting at slot transitions.
- `SSEG_MUX_BLANK_EN` undefined: there is no blanking, every slot cycle drives its digit, and `BLANK_CYCLES` is unused.

## Test plan
- Reset, N=4, no load → `an_o`=1111, `sseg_o`=7F, `dp_o`=1, `ready_o`=1 for 32 cycles; `frame_o` pulses every 16 cycles.
- Load 32'h7F3F_065B at cnt=5, all digits enabled, no blanking → `ready_o` low until the wrap. The next frame shows `an_o` 1110/1101/1011/0111 for 4 cycles each, with `sseg_o` 5B, 06, 3F, 7F and `dp_o`=0 on digit 0.
- Second load while `ready_o` is low (pattern 32'h0) → ignored; the first pattern is displayed and `ready_o` rises 1 cycle after the swap.
- Load coincident with the wrap edge while pending is empty → not shown in the following frame, shown in the frame after.
- `digit_en_i`=4'b0101 → digits 1 and 3 slots show `an_o`=1111 and `sseg_o`=7F; digits 0 and 2 unaffected.
- `SSEG_MUX_BLANK_EN` defined, N=5, BLANK_CYCLES=2 → the first 2 of every 8 slot cycles are all-off. Assert `rst_i` mid-frame → outputs return to reset values on the next cycle and the old pattern is never redisplayed.

Source files
------------

// File: rtl/sseg_mux_driver.sv
// Four-digit time-multiplexed seven-segment driver with a double-buffered pattern.
// Optional per-slot anode blanking is compiled in with SSEG_MUX_BLANK_EN.
module sseg_mux_driver #(
  parameter int N            = 18,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pattern_i,
  input  logic        load_i,
  output logic        ready_o,
  input  logic [3:0]  digit_en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  sseg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam logic [N-1:0] CNT_MAX = '1;

  if (N < 4) begin : g_bad_width
    $error("sseg_mux_driver: N must be at least 4");
  end
  if (BLANK_CYCLES >= (2 ** (N - 2))) begin : g_bad_blank
    $error("sseg_mux_driver: BLANK_CYCLES must be shorter than one slot");
  end

  logic [N-1:0] cnt;
  logic [31:0]  active;
  logic [31:0]  pending;
  logic         wrap;
  logic [1:0]   idx;
  logic [7:0]   cur_byte;
  logic         show;

`ifdef SSEG_MUX_BLANK_EN
  localparam logic [N-3:0] BLANK_TH = BLANK_CYCLES[N-3:0];
`endif

  always_comb begin
    wrap     = (cnt == CNT_MAX);
    idx      = cnt[N-1:N-2];
    cur_byte = active[{idx, 3'b000} +: 8];
    show     = digit_en_i[idx];
`ifdef SSEG_MUX_BLANK_EN
    if (cnt[N-3:0] < BLANK_TH) show = 1'b0;
`endif
  end

  // ready_o doubles as the "pending empty" flag; the swap takes priority on the wrap edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      active  <= 32'hFFFF_FFFF;
      pending <= 32'hFFFF_FFFF;
      ready_o <= 1'b1;
      an_o    <= 4'b1111;
      sseg_o  <= 7'h7F;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      frame_o <= wrap;
      if (wrap && !ready_o) begin
        active  <= pending;
        ready_o <= 1'b1;
      end else if (load_i && ready_o) begin
        pending <= pattern_i;
        ready_o <= 1'b0;
      end
      if (show) begin
        an_o   <= ~(4'b0001 << idx);
        sseg_o <= cur_byte[6:0];
        dp_o   <= cur_byte[7];
      end else begin
        an_o   <= 4'b1111;
        sseg_o <= 7'h7F;
        dp_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver at N=4 (16-cycle frame, 4-cycle slots).
// Expectations follow blanking when SSEG_MUX_BLANK_EN is defined.
module tb_sseg_mux_driver;

  localparam int N     = 4;
  localparam int BLANK = 2;
`ifdef SSEG_MUX_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  localparam logic [31:0] PAT_A = 32'h7F3F_065B;
  localparam logic [31:0] PAT_B = 32'hC0F9_A4B0;
  localparam logic [31:0] PAT_OFF = 32'hFFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pattern_i;
  logic        load_i;
  logic        ready_o;
  logic [3:0]  digit_en_i;
  logic [3:0]  an_o;
  logic [6:0]  sseg_o;
  logic        dp_o;
  logic        frame_o;

  int checks = 0;
  int passed = 0;
  int tcnt   = 0;

  sseg_mux_driver #(.N(N), .BLANK_CYCLES(BLANK)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pattern_i  (pattern_i),
    .load_i     (load_i),
    .ready_o    (ready_o),
    .digit_en_i (digit_en_i),
    .an_o       (an_o),
    .sseg_o     (sseg_o),
    .dp_o       (dp_o),
    .frame_o    (frame_o)
  );

  always #5 clk_i = ~clk_i;

  // tcnt tracks the DUT refresh count in the cycle just after each edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    tcnt = (tcnt + 1) % 16;
  endtask

  // Pins expected in the cycle where the counter reads c: they show count c-1.
  function automatic logic [11:0] exp_disp(input logic [31:0] pat, input logic [3:0] en,
                                           input int c);
    int pre;
    int d;
    logic [7:0] b;
    logic [3:0] a;
    pre = (c + 15) % 16;
    d   = pre / 4;
    b   = pat[8*d +: 8];
    a   = ~(4'b0001 << d);
    if (!en[d] || (BLANK_ON && (pre % 4) < BLANK)) return {4'b1111, 7'h7F, 1'b1};
    return {a, b[6:0], b[7]};
  endfunction

  task automatic test_reset();
    logic [11:0] e;
    rst_i = 1'b1;
    load_i = 1'b0;
    pattern_i = 32'h0;
    digit_en_i = 4'b0000;
    step();
    step();
    rst_i = 1'b0;
    tcnt = 0;
    checks++;
    if ({an_o, sseg_o, dp_o, ready_o, frame_o} !== {4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0})
      $display("[TB] FAIL reset_values got %h required %h",
               {an_o, sseg_o, dp_o, ready_o, frame_o}, {4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0});
    else passed++;
    for (int k = 0; k < 32; k++) begin
      step();
      e = exp_disp(PAT_OFF, 4'b0000, tcnt);
      checks++;
      if ({an_o, sseg_o, dp_o, ready_o} !== {e, 1'b1})
        $display("[TB] FAIL reset_idle cyc=%0d got %h required %h", k,
                 {an_o, sseg_o, dp_o, ready_o}, {e, 1'b1});
      else passed++;
      checks++;
      if (frame_o !== (tcnt == 0))
        $display("[TB] FAIL reset_frame cyc=%0d got %b required %b", k, frame_o, tcnt == 0);
      else passed++;
    end
  endtask

  task automatic test_load_and_ignored();
    logic [3:0] tab_an [4];
    logic [6:0] tab_seg [4];
    logic [11:0] e;
    tab_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tab_seg = '{7'h5B, 7'h06, 7'h3F, 7'h7F};
    digit_en_i = 4'b1111;
    while (tcnt != 5) step();
    pattern_i = PAT_A;
    load_i = 1'b1;
    step();
    checks++;
    if (ready_o !== 1'b0) $display("[TB] FAIL ready_after_load got %b required 0", ready_o);
    else passed++;
    // Second load with ready low, held high through the wrap edge too.
    pattern_i = 32'h0;
    while (tcnt != 0) begin
      step();
      e = exp_disp(PAT_OFF, 4'b1111, tcnt);
      checks++;
      if ({an_o, sseg_o, dp_o} !== e)
        $display("[TB] FAIL predisplay tcnt=%0d got %h required %h", tcnt, {an_o, sseg_o, dp_o}, e);
      else passed++;
      checks++;
      if (ready_o !== (tcnt == 0))
        $display("[TB] FAIL ready_pending tcnt=%0d got %b required %b", tcnt, ready_o, tcnt == 0);
      else passed++;
    end
    load_i = 1'b0;
    checks++;
    if (frame_o !== 1'b1) $display("[TB] FAIL frame_at_swap got %b required 1", frame_o);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      step();
      if (BLANK_ON && (k % 4) < BLANK) e = {4'b1111, 7'h7F, 1'b1};
      else e = {tab_an[k/4], tab_seg[k/4], 1'b0};
      checks++;
      if ({an_o, sseg_o, dp_o} !== e)
        $display("[TB] FAIL display_a k=%0d got %h required %h", k, {an_o, sseg_o, dp_o}, e);
      else passed++;
      checks++;
      if (ready_o !== 1'b1) $display("[TB] FAIL ready_idle_a k=%0d got %b required 1", k, ready_o);
      else passed++;
    end
  endtask

  task automatic test_wrap_load();
    logic [11:0] e;
    while (tcnt != 15) step();
    pattern_i = PAT_B;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) $display("[TB] FAIL wrap_load_captured got %b required 0", ready_o);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      step();
      e = exp_disp(PAT_A, 4'b1111, tcnt);
      checks++;
      if ({an_o, sseg_o, dp_o} !== e)
        $display("[TB] FAIL wrap_old_frame tcnt=%0d got %h required %h", tcnt, {an_o, sseg_o, dp_o}, e);
      else passed++;
      checks++;
      if (ready_o !== (tcnt == 0))
        $display("[TB] FAIL wrap_ready tcnt=%0d got %b required %b", tcnt, ready_o, tcnt == 0);
      else passed++;
    end
    for (int k = 0; k < 16; k++) begin
      step();
      e = exp_disp(PAT_B, 4'b1111, tcnt);
      checks++;
      if ({an_o, sseg_o, dp_o} !== e)
        $display("[TB] FAIL wrap_new_frame tcnt=%0d got %h required %h", tcnt, {an_o, sseg_o, dp_o}, e);
      else passed++;
    end
  endtask

  task automatic test_digit_enable();
    logic [11:0] e;
    digit_en_i = 4'b0101;
    for (int k = 0; k < 16; k++) begin
      step();
      e = exp_disp(PAT_B, 4'b0101, tcnt);
      checks++;
      if ({an_o, sseg_o, dp_o} !== e)
        $display("[TB] FAIL digit_enable tcnt=%0d got %h required %h", tcnt, {an_o, sseg_o, dp_o}, e);
      else passed++;
    end
    digit_en_i = 4'b1111;
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    while (tcnt != 3) step();
    pattern_i = 32'h0;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) $display("[TB] FAIL mid_load_accepted got %b required 0", ready_o);
    else passed++;
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    tcnt = 0;
    checks++;
    if ({an_o, sseg_o, dp_o, ready_o, frame_o} !== {4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0})
      $display("[TB] FAIL mid_reset_values got %h required %h",
               {an_o, sseg_o, dp_o, ready_o, frame_o}, {4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0});
    else passed++;
    for (int k = 0; k < 20; k++) begin
      step();
      e = exp_disp(PAT_OFF, 4'b1111, tcnt);
      checks++;
      if ({an_o, sseg_o, dp_o, ready_o, frame_o} !== {e, 1'b1, tcnt == 0})
        $display("[TB] FAIL post_reset tcnt=%0d got %h required %h", tcnt,
                 {an_o, sseg_o, dp_o, ready_o, frame_o}, {e, 1'b1, tcnt == 0});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load_and_ignored();
    test_wrap_load();
    test_digit_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
